// File: rtl/diff_manchester_enc_if.sv
// AXI-Stream beat bundle shared by the encoder's input and output sides.
// The master drives valid/last/data/strb and the slave answers with ready.
interface diff_manchester_enc_if #(
    parameter int DATA_W = 32
);
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic [DATA_W-1:0]     tdata;
    logic [DATA_W/8-1:0]   tstrb;

    modport master (output tvalid, tlast, tdata, tstrb, input tready);
    modport slave  (input tvalid, tlast, tdata, tstrb, output tready);
endinterface

// File: rtl/diff_manchester_enc.sv
// Differential-Manchester line encoder: one input bit becomes 2*SAMPLES_PER_CHIP chip beats.
// Define DIFF_MANCHESTER_ENC_PREAMBLE_EN to emit PREAMBLE_BITS zero bits after reset and after every packet.
module diff_manchester_enc #(
    parameter int C_S00_AXIS_TDATA_WIDTH = 32,
    parameter int C_M00_AXIS_TDATA_WIDTH = 32,
    parameter int SAMPLES_PER_CHIP       = 1,
    parameter int PREAMBLE_BITS          = 8
) (
    input  logic                          s00_axis_aclk,
    input  logic                          s00_axis_areset,
    diff_manchester_enc_if.slave          s00_axis,
    diff_manchester_enc_if.master         m00_axis
);

    localparam int               CNT_W  = $clog2(2 * SAMPLES_PER_CHIP) + 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(2 * SAMPLES_PER_CHIP - 1);
    localparam logic [CNT_W-1:0] HALF   = CNT_W'(SAMPLES_PER_CHIP);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    logic [C_S00_AXIS_TDATA_WIDTH-1:0]   s_data;
    logic [C_S00_AXIS_TDATA_WIDTH/8-1:0] s_strb;
    logic                                unused_in;

    assign s_data    = s00_axis.tdata;
    assign s_strb    = s00_axis.tstrb;
    assign unused_in = ^{s_strb, s_data[C_S00_AXIS_TDATA_WIDTH-1:1]};

    logic             level_q, level_d;
    logic [CNT_W-1:0] rem_q,   rem_d;
    logic             bit_q,   bit_d;
    logic             blast_q, blast_d;
    logic             vld_q,   vld_d;
    logic             last_q,  last_d;
    logic             chip_q,  chip_d;

    logic slot_free;
    logic in_hs;
    logic end_of_bit;
    logic pre_active;
    logic pre_start;
    logic first_chip;
    logic in_first_chip;

    assign slot_free     = ~vld_q | m00_axis.tready;
    assign end_of_bit    = slot_free & (rem_q == ONE);
    assign in_hs         = s00_axis.tvalid & s00_axis.tready;
    assign first_chip    = bit_q ? level_q : ~level_q;
    assign in_first_chip = s_data[0] ? level_q : ~level_q;

    assign s00_axis.tready = slot_free & (rem_q == '0) & ~pre_active;

    assign m00_axis.tvalid = vld_q;
    assign m00_axis.tlast  = last_q;
    assign m00_axis.tdata  = C_M00_AXIS_TDATA_WIDTH'(chip_q);
    assign m00_axis.tstrb  = '1;

`ifdef DIFF_MANCHESTER_ENC_PREAMBLE_EN
    localparam int            PRE_W  = (PREAMBLE_BITS > 0) ? $clog2(PREAMBLE_BITS + 1) : 1;
    localparam logic [PRE_W-1:0] PRE_N  = PRE_W'(PREAMBLE_BITS);
    localparam logic [PRE_W-1:0] PRE_1  = PRE_W'(1);
    localparam logic             PRE_ON = (PREAMBLE_BITS > 0);

    logic             pre_active_q, pre_active_d;
    logic [PRE_W-1:0] pre_cnt_q,    pre_cnt_d;

    assign pre_active = pre_active_q;
    assign pre_start  = pre_active_q & slot_free & (rem_q == '0) & (pre_cnt_q != '0);

    // pre_cnt counts preamble bits not yet started; the flag drops with the final sample of the last one.
    always_comb begin
        pre_active_d = pre_active_q;
        pre_cnt_d    = pre_cnt_q;
        if (pre_start)
            pre_cnt_d = pre_cnt_q - PRE_1;
        if (end_of_bit && pre_active_q && (pre_cnt_q == '0))
            pre_active_d = 1'b0;
        if (end_of_bit && blast_q && PRE_ON) begin
            pre_active_d = 1'b1;
            pre_cnt_d    = PRE_N;
        end
    end

    always_ff @(posedge s00_axis_aclk) begin
        if (s00_axis_areset) begin
            pre_active_q <= PRE_ON;
            pre_cnt_q    <= PRE_N;
        end else begin
            pre_active_q <= pre_active_d;
            pre_cnt_q    <= pre_cnt_d;
        end
    end
`else
    logic unused_pre;

    assign pre_active = 1'b0;
    assign pre_start  = 1'b0;
    assign unused_pre = (PREAMBLE_BITS > 0);
`endif

    // Line level only moves once a bit's last sample is loaded, so both chips derive from one stable level.
    always_comb begin
        level_d = level_q;
        rem_d   = rem_q;
        bit_d   = bit_q;
        blast_d = blast_q;
        vld_d   = vld_q;
        last_d  = last_q;
        chip_d  = chip_q;
        if (in_hs) begin
            chip_d  = in_first_chip;
            vld_d   = 1'b1;
            last_d  = 1'b0;
            rem_d   = RELOAD;
            bit_d   = s_data[0];
            blast_d = s00_axis.tlast;
        end else if (pre_start) begin
            chip_d  = ~level_q;
            vld_d   = 1'b1;
            last_d  = 1'b0;
            rem_d   = RELOAD;
            bit_d   = 1'b0;
            blast_d = 1'b0;
        end else if (slot_free && (rem_q != '0)) begin
            chip_d = (rem_q > HALF) ? first_chip : ~first_chip;
            vld_d  = 1'b1;
            rem_d  = rem_q - ONE;
            last_d = (rem_q == ONE) & blast_q;
            if (rem_q == ONE)
                level_d = ~first_chip;
        end else if (slot_free) begin
            vld_d  = 1'b0;
            last_d = 1'b0;
        end
    end

    always_ff @(posedge s00_axis_aclk) begin
        if (s00_axis_areset) begin
            level_q <= 1'b1;
            rem_q   <= '0;
            bit_q   <= 1'b0;
            blast_q <= 1'b0;
            vld_q   <= 1'b0;
            last_q  <= 1'b0;
            chip_q  <= 1'b0;
        end else begin
            level_q <= level_d;
            rem_q   <= rem_d;
            bit_q   <= bit_d;
            blast_q <= blast_d;
            vld_q   <= vld_d;
            last_q  <= last_d;
            chip_q  <= chip_d;
        end
    end

    a_hold: assert property (@(posedge s00_axis_aclk) disable iff (s00_axis_areset)
        (vld_q && !m00_axis.tready) |=> (vld_q && $stable(chip_q) && $stable(last_q)));

    a_last_valid: assert property (@(posedge s00_axis_aclk) disable iff (s00_axis_areset)
        last_q |-> vld_q);

endmodule

// File: tb/tb_diff_manchester_enc.sv
// Bench for diff_manchester_enc: two encoders (1 and 2 samples per chip) against a per-bit reference model.
module tb_diff_manchester_enc;
`ifdef DIFF_MANCHESTER_ENC_PREAMBLE_EN
    localparam int PRE = 2;
`else
    localparam int PRE = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    diff_manchester_enc_if #(.DATA_W(32)) a_s();
    diff_manchester_enc_if #(.DATA_W(32)) a_m();
    diff_manchester_enc_if #(.DATA_W(32)) b_s();
    diff_manchester_enc_if #(.DATA_W(32)) b_m();

    diff_manchester_enc #(.SAMPLES_PER_CHIP(1), .PREAMBLE_BITS(2)) dut_a (
        .s00_axis_aclk(clk), .s00_axis_areset(rst), .s00_axis(a_s), .m00_axis(a_m));
    diff_manchester_enc #(.SAMPLES_PER_CHIP(2), .PREAMBLE_BITS(2)) dut_b (
        .s00_axis_aclk(clk), .s00_axis_areset(rst), .s00_axis(b_s), .m00_axis(b_m));

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int hi_err = 0;
    bit rnd_rdy = 1'b0;
    bit lvl[2];
    logic [1:0] got_a[$], got_b[$], exp_a[$], exp_b[$];
    int gc_a[$], gc_b[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Records every accepted output beat as {tlast, chip} with the cycle it was taken.
    always @(posedge clk) begin
        if (!rst) begin
            if (a_m.tvalid && a_m.tready) begin
                got_a.push_back({a_m.tlast, a_m.tdata[0]});
                gc_a.push_back(cyc);
                if (a_m.tdata[31:1] != 0) hi_err <= hi_err + 1;
            end
            if (b_m.tvalid && b_m.tready) begin
                got_b.push_back({b_m.tlast, b_m.tdata[0]});
                gc_b.push_back(cyc);
                if (b_m.tdata[31:1] != 0) hi_err <= hi_err + 1;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (rnd_rdy) begin
            a_m.tready = ($urandom_range(0, 3) != 0);
            b_m.tready = ($urandom_range(0, 2) != 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

    // One encoded bit: first half-bit F (transition at start only for a 0), second half ~F.
    task automatic model_one(input int d, input bit b, input bit last);
        int spc;
        bit f;
        logic [1:0] s;
        spc = (d == 0) ? 1 : 2;
        f = b ? lvl[d] : ~lvl[d];
        for (int i = 0; i < 2 * spc; i++) begin
            s = {last && (i == 2 * spc - 1), (i < spc) ? f : ~f};
            if (d == 0) exp_a.push_back(s); else exp_b.push_back(s);
        end
        lvl[d] = ~f;
    endtask

    task automatic model_bit(input int d, input bit b, input bit last);
        model_one(d, b, last);
        if (last)
            for (int k = 0; k < PRE; k++) model_one(d, 1'b0, 1'b0);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        a_s.tvalid = 1'b0;
        b_s.tvalid = 1'b0;
        a_m.tready = 1'b1;
        b_m.tready = 1'b1;
        repeat (n) @(negedge clk);
        got_a.delete(); got_b.delete(); exp_a.delete(); exp_b.delete();
        gc_a.delete(); gc_b.delete();
        lvl[0] = 1'b1;
        lvl[1] = 1'b1;
        for (int k = 0; k < PRE; k++) begin
            model_one(0, 1'b0, 1'b0);
            model_one(1, 1'b0, 1'b0);
        end
        rst = 1'b0;
    endtask

    // Presents one bit (junk in the unused data bits) and returns at the negedge after its handshake.
    task automatic send(input int d, input bit b, input bit last, output int hs);
        int n;
        logic [31:0] w;
        n = 0;
        hs = -1;
        w = $urandom;
        w[0] = b;
        if (d == 0) begin
            a_s.tdata = w; a_s.tstrb = 4'($urandom); a_s.tlast = last; a_s.tvalid = 1'b1;
        end else begin
            b_s.tdata = w; b_s.tstrb = 4'($urandom); b_s.tlast = last; b_s.tvalid = 1'b1;
        end
        forever begin
            #1;
            if ((d == 0) ? a_s.tready : b_s.tready) break;
            n++;
            if (n > 500) break;
            @(negedge clk);
        end
        if (n > 500) begin
            total++; bad++;
            $display("FAIL send_timeout dut=%0d got=no_handshake want=handshake", d);
        end else begin
            hs = cyc;
            model_bit(d, b, last);
            @(negedge clk);
        end
        if (d == 0) a_s.tvalid = 1'b0; else b_s.tvalid = 1'b0;
    endtask

    task automatic wait_beats(input int d, input int n);
        int t;
        t = 0;
        while ((((d == 0) ? got_a.size() : got_b.size()) < n) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        repeat (12) @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset(3);
        total++; if (a_m.tvalid !== 1'b0) begin bad++; $display("FAIL reset_tvalid_a got=%b want=0", a_m.tvalid); end
        total++; if (a_m.tlast !== 1'b0) begin bad++; $display("FAIL reset_tlast_a got=%b want=0", a_m.tlast); end
        total++; if (a_m.tdata !== 32'h0) begin bad++; $display("FAIL reset_tdata_a got=%h want=0", a_m.tdata); end
        total++; if (b_m.tvalid !== 1'b0) begin bad++; $display("FAIL reset_tvalid_b got=%b want=0", b_m.tvalid); end
        total++; if (b_m.tdata !== 32'h0) begin bad++; $display("FAIL reset_tdata_b got=%h want=0", b_m.tdata); end
        total++; if (a_m.tstrb !== 4'hF) begin bad++; $display("FAIL tstrb_a got=%h want=f", a_m.tstrb); end
        total++; if (b_m.tstrb !== 4'hF) begin bad++; $display("FAIL tstrb_b got=%h want=f", b_m.tstrb); end
        total++; if (a_s.tready !== (PRE == 0)) begin bad++; $display("FAIL reset_sready_a got=%b want=%0d", a_s.tready, PRE == 0); end
        total++; if (b_s.tready !== (PRE == 0)) begin bad++; $display("FAIL reset_sready_b got=%b want=%0d", b_s.tready, PRE == 0); end
    endtask

    task automatic test_basic();
        int hs[4];
        bit bits[4];
        logic [7:0] lit;
        logic [1:0] w;
        int off;
        bits = '{1'b1, 1'b0, 1'b0, 1'b1};
        lit = 8'b10101001;
        off = 2 * PRE;
        do_reset(2);
        for (int i = 0; i < 4; i++) send(0, bits[i], i == 3, hs[i]);
        wait_beats(0, exp_a.size());
        total++;
        if (got_a.size() != exp_a.size()) begin bad++; $display("FAIL basic_count got=%0d want=%0d", got_a.size(), exp_a.size()); end
        for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
            total++;
            if (got_a[i] !== exp_a[i]) begin bad++; $display("FAIL basic_beat%0d got=%b want=%b", i, got_a[i], exp_a[i]); end
        end
        for (int i = 0; i < 8 && off + i < got_a.size(); i++) begin
            w = {1'(i == 7), lit[7-i]};
            total++;
            if (got_a[off+i] !== w) begin bad++; $display("FAIL basic_table%0d got=%b want=%b", i, got_a[off+i], w); end
        end
        total++;
        if (gc_a.size() <= off || gc_a[off] != hs[0] + 1) begin
            bad++; $display("FAIL basic_latency got=%0d want=%0d", (gc_a.size() > off) ? gc_a[off] : -1, hs[0] + 1);
        end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (hs[i+1] - hs[i] != 2) begin bad++; $display("FAIL basic_accept_gap%0d got=%0d want=2", i, hs[i+1] - hs[i]); end
        end
    endtask

    task automatic test_spc2();
        int hs;
        logic [7:0] lit;
        logic [1:0] w;
        int off;
        lit = 8'b00111100;
        off = 4 * PRE;
        do_reset(2);
        send(1, 1'b0, 1'b0, hs);
        send(1, 1'b1, 1'b0, hs);
        wait_beats(1, exp_b.size());
        total++;
        if (got_b.size() != exp_b.size()) begin bad++; $display("FAIL spc2_count got=%0d want=%0d", got_b.size(), exp_b.size()); end
        for (int i = 0; i < exp_b.size() && i < got_b.size(); i++) begin
            total++;
            if (got_b[i] !== exp_b[i]) begin bad++; $display("FAIL spc2_beat%0d got=%b want=%b", i, got_b[i], exp_b[i]); end
        end
        for (int i = 0; i < 8 && off + i < got_b.size(); i++) begin
            w = {1'b0, lit[7-i]};
            total++;
            if (got_b[off+i] !== w) begin bad++; $display("FAIL spc2_table%0d got=%b want=%b", i, got_b[off+i], w); end
        end
    endtask

    task automatic test_backpressure();
        int hs;
        int off;
        logic want;
        off = 2 * PRE;
        do_reset(2);
        send(0, 1'b1, 1'b0, hs);
        @(negedge clk);
        a_m.tready = 1'b0;
        a_s.tdata = 32'h0;
        a_s.tlast = 1'b0;
        a_s.tvalid = 1'b1;
        want = exp_a[off+1][0];
        for (int c = 0; c < 3; c++) begin
            #1;
            total++; if (a_m.tvalid !== 1'b1) begin bad++; $display("FAIL bp_tvalid%0d got=%b want=1", c, a_m.tvalid); end
            total++; if (a_m.tdata[0] !== want) begin bad++; $display("FAIL bp_tdata%0d got=%b want=%b", c, a_m.tdata[0], want); end
            total++; if (a_s.tready !== 1'b0) begin bad++; $display("FAIL bp_sready%0d got=%b want=0", c, a_s.tready); end
            @(negedge clk);
        end
        a_m.tready = 1'b1;
        send(0, 1'b0, 1'b1, hs);
        wait_beats(0, exp_a.size());
        total++;
        if (got_a.size() != exp_a.size()) begin bad++; $display("FAIL bp_count got=%0d want=%0d", got_a.size(), exp_a.size()); end
        for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
            total++;
            if (got_a[i] !== exp_a[i]) begin bad++; $display("FAIL bp_beat%0d got=%b want=%b", i, got_a[i], exp_a[i]); end
        end
    endtask

    task automatic test_reset_midbit();
        int hs;
        int off;
        off = 2 * PRE;
        do_reset(2);
        send(0, 1'b1, 1'b0, hs);
        do_reset(1);
        total++; if (a_m.tvalid !== 1'b0) begin bad++; $display("FAIL midrst_tvalid got=%b want=0", a_m.tvalid); end
        total++; if (a_m.tlast !== 1'b0) begin bad++; $display("FAIL midrst_tlast got=%b want=0", a_m.tlast); end
        send(0, 1'b0, 1'b0, hs);
        wait_beats(0, exp_a.size());
        total++;
        if (got_a.size() != off + 2) begin bad++; $display("FAIL midrst_count got=%0d want=%0d", got_a.size(), off + 2); end
        total++;
        if (got_a.size() > off + 1 && got_a[off] !== 2'b00) begin bad++; $display("FAIL midrst_chip0 got=%b want=00", got_a[off]); end
        total++;
        if (got_a.size() > off + 1 && got_a[off+1] !== 2'b01) begin bad++; $display("FAIL midrst_chip1 got=%b want=01", got_a[off+1]); end
    endtask

    task automatic test_back_to_back();
        int hs[6];
        do_reset(2);
        for (int i = 0; i < 6; i++) send(0, 1'($urandom), (i == 2) || (i == 5), hs[i]);
        wait_beats(0, exp_a.size());
        total++;
        if (got_a.size() != exp_a.size()) begin bad++; $display("FAIL b2b_count got=%0d want=%0d", got_a.size(), exp_a.size()); end
        for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
            total++;
            if (got_a[i] !== exp_a[i]) begin bad++; $display("FAIL b2b_beat%0d got=%b want=%b", i, got_a[i], exp_a[i]); end
        end
        for (int i = 0; i + 1 < gc_a.size(); i++) begin
            total++;
            if (gc_a[i+1] != gc_a[i] + 1) begin bad++; $display("FAIL b2b_idle%0d got=%0d want=%0d", i, gc_a[i+1], gc_a[i] + 1); end
        end
        total++;
        if (hs[3] - hs[2] != 2 * (1 + PRE)) begin bad++; $display("FAIL b2b_packet_gap got=%0d want=%0d", hs[3] - hs[2], 2 * (1 + PRE)); end
    endtask

    task automatic test_random();
        do_reset(2);
        hi_err = 0;
        rnd_rdy = 1'b1;
        fork
            begin
                int h;
                for (int i = 0; i < 40; i++) send(0, 1'($urandom), $urandom_range(0, 3) == 0, h);
            end
            begin
                int h;
                for (int i = 0; i < 25; i++) send(1, 1'($urandom), $urandom_range(0, 3) == 0, h);
            end
        join
        rnd_rdy = 1'b0;
        a_m.tready = 1'b1;
        b_m.tready = 1'b1;
        wait_beats(0, exp_a.size());
        wait_beats(1, exp_b.size());
        total++;
        if (got_a.size() != exp_a.size()) begin bad++; $display("FAIL rnd_count_a got=%0d want=%0d", got_a.size(), exp_a.size()); end
        for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
            total++;
            if (got_a[i] !== exp_a[i]) begin bad++; $display("FAIL rnd_a_beat%0d got=%b want=%b", i, got_a[i], exp_a[i]); end
        end
        total++;
        if (got_b.size() != exp_b.size()) begin bad++; $display("FAIL rnd_count_b got=%0d want=%0d", got_b.size(), exp_b.size()); end
        for (int i = 0; i < exp_b.size() && i < got_b.size(); i++) begin
            total++;
            if (got_b[i] !== exp_b[i]) begin bad++; $display("FAIL rnd_b_beat%0d got=%b want=%b", i, got_b[i], exp_b[i]); end
        end
        total++;
        if (hi_err != 0) begin bad++; $display("FAIL rnd_upper_bits got=%0d want=0", hi_err); end
    endtask

    initial begin
        a_s.tvalid = 1'b0; a_s.tlast = 1'b0; a_s.tdata = '0; a_s.tstrb = '0;
        b_s.tvalid = 1'b0; b_s.tlast = 1'b0; b_s.tdata = '0; b_s.tstrb = '0;
        a_m.tready = 1'b1; b_m.tready = 1'b1;
        @(negedge clk);
        test_reset();
        test_basic();
        test_spc2();
        test_backpressure();
        test_reset_midbit();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/diff_manchester_enc.md
Name: diff_manchester_enc

Overview:
- AXI-Stream differential-Manchester line encoder, the transmit-side counterpart of the receive-path differential bit decoder.
- Accepts one data bit per input beat in tdata[0]. Emits 2*SAMPLES_PER_CHIP output beats per bit, each carrying one chip level in tdata[0].
- Sits between the packet/bit source and the BPSK modulator on the transmit path.

Parameters:
- C_S00_AXIS_TDATA_WIDTH, 32, input stream width; only bit 0 is used.
- C_M00_AXIS_TDATA_WIDTH, 32, output stream width; chip level in bit 0, all other bits 0.
- SAMPLES_PER_CHIP, 1, output beats per half-bit (chip); must be >= 1.
- PREAMBLE_BITS, 8, number of preamble bits; used only with the optional feature.

Ports:
- s00_axis_aclk  in  1  sole clock.
- s00_axis_areset  in  1  synchronous reset, active-high.
- s00_axis_tvalid  in  1  input bit valid.
- s00_axis_tlast  in  1  input bit is the last bit of the packet.
- s00_axis_tdata  in  C_S00_AXIS_TDATA_WIDTH  data bit in [0].
- s00_axis_tstrb  in  C_S00_AXIS_TDATA_WIDTH/8  ignored.
- s00_axis_tready  out  1  encoder can accept a bit.
- m00_axis_tready  in  1  downstream ready.
- m00_axis_tvalid  out  1  chip sample valid.
- m00_axis_tlast  out  1  final sample of a tlast bit.
- m00_axis_tdata  out  C_M00_AXIS_TDATA_WIDTH  {zeros, chip}.
- m00_axis_tstrb  out  C_M00_AXIS_TDATA_WIDTH/8  constant all-ones.

Behaviour:
- Reset (synchronous, s00_axis_areset=1):
  - m00_axis_tvalid=0, m00_axis_tlast=0, m00_axis_tdata=0.
  - Line level L=1, remaining=0.
  - Any partially sent bit is discarded; reset is honoured mid-bit.
- Encoding for bit b given current line level L:
  - first chip F = b ? L : ~L, so a 0 bit has a transition at the bit start and a 1 bit has none.
  - second chip S = ~F, so every bit has a mid-bit transition.
  - After the bit, L <= S.
- Output register:
  - slot_free = ~m00_axis_tvalid | m00_axis_tready.
  - Output beats are registered; an output beat is held stable until its handshake completes.
- remaining counter, range 0..2*SAMPLES_PER_CHIP-1:
  - Counts samples still to emit for the current bit.
- Input acceptance:
  - s00_axis_tready = slot_free & (remaining==0) & ~preamble_active.
- On an input handshake, in the same edge:
  - output register loads F with tvalid=1.
  - remaining <= 2*SAMPLES_PER_CHIP-1.
  - The bit value and its tlast are latched.
- Otherwise, if slot_free and remaining>0:
  - Load the next sample: F while more than SAMPLES_PER_CHIP samples remain, else S.
  - Decrement remaining.
  - When remaining goes 1->0, set m00_axis_tlast to the latched tlast and update L.
- Otherwise, if slot_free and nothing is pending: tvalid <= 0, tlast <= 0.
- Latency and throughput:
  - Input handshake at edge N -> first sample visible at N+1.
  - With continuous downstream ready: one bit per 2*SAMPLES_PER_CHIP cycles, no bubbles between bits.
- Backpressure: while m00_axis_tready=0 and tvalid=1, all state is frozen and s00_axis_tready=0.
- m00_axis_tlast is asserted only on the final sample of a bit whose input tlast=1.
- L persists across packets; it is reset only by s00_axis_areset.

Optional Feature:
- Macro: DIFF_MANCHESTER_ENC_PREAMBLE_EN.
- When defined:
  - After reset, and after the final sample of any tlast bit, preamble_active=1.
  - While preamble_active, the encoder autonomously emits PREAMBLE_BITS encoded 0 bits (2*SAMPLES_PER_CHIP samples each, tlast=0). These bits follow the same L update rules.
  - s00_axis_tready=0 during the preamble.
  - preamble_active clears after the last preamble sample is loaded.
- When undefined: preamble_active is constant 0 and no preamble logic exists.

Test Plan:
- SPC=1, no preamble, reset, bits 1,0,0,1 (last tlast=1) with m00_axis_tready=1 -> chips 1,0,1,0,1,0,0,1; tlast only on the 8th beat; s00_axis_tready high every 2nd cycle.
- SPC=2, single bit 0 after reset -> samples 0,0,1,1; next bit 1 -> 1,1,0,0.
- Backpressure: drop m00_axis_tready for 3 cycles mid-bit -> tdata and tvalid held; s00_axis_tready=0; sequence resumes with no lost or duplicated samples.
- Reset asserted after the first chip of bit 1 -> next cycle tvalid=0; following bit 0 emits 0,1 (L restored to 1).
- Two packets back-to-back: tlast on packet 1's last bit only; packet 2's first chip follows with zero idle cycles; L carries across packets.
- DIFF_MANCHESTER_ENC_PREAMBLE_EN, PREAMBLE_BITS=2, SPC=1 -> after reset, 0,1,0,1 is emitted with s00_axis_tready=0, then input bits are accepted; the preamble repeats after a tlast bit.
